// File: rtl/rotor_param_ctrl.sv
// Encoder/button driven editor for a small bank of 8-bit parameters with
// saturation, speed-dependent acceleration and a valid/ready update port.
module rotor_param_ctrl #(
    parameter int NUM_PARAMS   = 4,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 255,
    parameter int INIT_VAL     = 0,
    parameter int ACCEL_WINDOW = 2500000,
    parameter int ACCEL_THRESH = 3,
    parameter int ACCEL_STEP   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_up_i,
    input  logic       step_dn_i,
    input  logic       btn_press_i,
    input  logic       upd_ready_i,
    output logic [1:0] sel_o,
    output logic [7:0] value_o,
    output logic       upd_valid_o,
    output logic [1:0] upd_addr_o,
    output logic [7:0] upd_data_o,
    output logic       busy_o
);
    localparam int WW = $clog2(ACCEL_WINDOW + 1);
    localparam int FW = $clog2(ACCEL_THRESH + 1);
    localparam logic [1:0]    SEL_LAST = 2'(NUM_PARAMS - 1);
    localparam logic [8:0]    MIN9     = 9'(MIN_VAL);
    localparam logic [8:0]    MAX9     = 9'(MAX_VAL);
    localparam logic [8:0]    ACC9     = 9'(ACCEL_STEP);
    localparam logic [7:0]    INIT8    = 8'(INIT_VAL);
    localparam logic [WW-1:0] WIN      = WW'(ACCEL_WINDOW);
    localparam logic [FW-1:0] THR      = FW'(ACCEL_THRESH);

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    params_q [NUM_PARAMS];
    logic [7:0]    params_d [NUM_PARAMS];
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    value_q, value_d;
    logic          upd_valid_q, upd_valid_d;
    logic [1:0]    upd_addr_q, upd_addr_d;
    logic [7:0]    upd_data_q, upd_data_d;
    logic [WW-1:0] win_q, win_d;
    logic [FW-1:0] fast_q, fast_s, fast_d;
    logic          dir_q, dir_d, prev_q, prev_d;
    logic          dirty_q, dirty_d, pend_q, pend_d;

    logic          step_ok, is_fast, changed, adv;
    logic [8:0]    cur9, step9, new9;
    logic [7:0]    new_val;

    // Step qualification, acceleration tracking and clamped arithmetic.
    always_comb begin
        step_ok = step_up_i ^ step_dn_i;
        win_d   = (win_q == WIN) ? win_q : win_q + 1'b1;
        fast_s  = (win_q == WIN) ? '0 : fast_q;
        dir_d   = dir_q;
        prev_d  = prev_q;
        is_fast = prev_q && (win_q < WIN) && (step_up_i == dir_q);
        if (step_ok) begin
            win_d  = '0;
            dir_d  = step_up_i;
            prev_d = 1'b1;
            if (is_fast)
                fast_s = (fast_q == THR) ? fast_q : fast_q + 1'b1;
            else
                fast_s = '0;
        end
        step9 = (fast_s >= THR) ? ACC9 : 9'd1;
        cur9  = {1'b0, params_q[sel_q]};
        if (step_up_i)
            new9 = (cur9 + step9 > MAX9) ? MAX9 : cur9 + step9;
        else
            new9 = (cur9 < MIN9 + step9) ? MIN9 : cur9 - step9;
        new_val = new9[7:0];
        changed = step_ok && (new_val != params_q[sel_q]);
    end

    generate
        for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
            assign params_d[gi] = (changed && sel_q == 2'(gi)) ? new_val : params_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) params_q[gi] <= INIT8;
                else        params_q[gi] <= params_d[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        upd_valid_d = upd_valid_q;
        upd_addr_d  = upd_addr_q;
        upd_data_d  = upd_data_q;
        dirty_d     = dirty_q;
        pend_d      = pend_q;
        fast_d      = fast_s;
        adv         = 1'b0;
        case (state_q)
            IDLE: begin
                if (changed) begin
                    state_d     = COMMIT;
                    upd_valid_d = 1'b1;
                    upd_addr_d  = sel_q;
                    upd_data_d  = new_val;
                    // A press arriving with a committing step waits until that update is sent.
                    pend_d      = pend_q | btn_press_i;
                end else if (pend_q | btn_press_i) begin
                    adv    = 1'b1;
                    pend_d = 1'b0;
                end
            end
            COMMIT: begin
                pend_d = pend_q | btn_press_i;
                if (upd_ready_i) begin
                    if (dirty_q | changed) begin
                        upd_data_d = params_d[upd_addr_q];
                        dirty_d    = 1'b0;
                    end else begin
                        upd_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (changed) begin
                    dirty_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            sel_d  = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
            fast_d = '0;
        end
        value_d = params_d[sel_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            value_q     <= INIT8;
            upd_valid_q <= 1'b0;
            upd_addr_q  <= 2'd0;
            upd_data_q  <= 8'd0;
            win_q       <= '0;
            fast_q      <= '0;
            dir_q       <= 1'b0;
            prev_q      <= 1'b0;
            dirty_q     <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            value_q     <= value_d;
            upd_valid_q <= upd_valid_d;
            upd_addr_q  <= upd_addr_d;
            upd_data_q  <= upd_data_d;
            win_q       <= win_d;
            fast_q      <= fast_d;
            dir_q       <= dir_d;
            prev_q      <= prev_d;
            dirty_q     <= dirty_d;
            pend_q      <= pend_d;
        end
    end

    assign sel_o       = sel_q;
    assign value_o     = value_q;
    assign upd_valid_o = upd_valid_q;
    assign upd_addr_o  = upd_addr_q;
    assign upd_data_o  = upd_data_q;
    assign busy_o      = (state_q == COMMIT) | dirty_q | pend_q;

endmodule
